// File: rtl/ssd1963_rx_if.sv
// Host-side 8080-style parallel bus of the SSD1963 target model.
// master = host driving the pads, slave = ssd1963_rx.
interface ssd1963_rx_if;
    logic       cs_n;
    logic       dc_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;

    modport master (output cs_n, dc_n, wr_n, rd_n, d_in, input d_out, d_oe);
    modport slave  (input cs_n, dc_n, wr_n, rd_n, d_in, output d_out, d_oe);
endinterface

// File: rtl/ssd1963_rx.sv
// SSD1963 8080-bus target: decodes the command/parameter stream into pixels with
// frame coordinates and answers power-mode reads. Define SSD1963_RX_RGB565_EN for 2-byte RGB565 pixels.
module ssd1963_rx #(
    parameter int X_W = 11,
    parameter int Y_W = 11
) (
    input  logic           clk,
    input  logic           reset,
    ssd1963_rx_if.slave    bus,
    output logic           pix_valid,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [23:0]    pix_data,
    output logic           disp_on
);

    localparam logic [7:0] CMD_COL     = 8'h2A;
    localparam logic [7:0] CMD_PAGE    = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMCONT = 8'h3C;
    localparam logic [7:0] CMD_OFF     = 8'h28;
    localparam logic [7:0] CMD_ON      = 8'h29;
    localparam logic [7:0] CMD_PWR     = 8'h0A;

`ifdef SSD1963_RX_RGB565_EN
    localparam logic [1:0] PIX_LAST = 2'd1;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] v);
        return {v[15:11], v[15:13], v[10:5], v[10:9], v[4:0], v[4:2]};
    endfunction
`else
    localparam logic [1:0] PIX_LAST = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_IGNORE = 2'd0,
        ST_COL    = 2'd1,
        ST_PAGE   = 2'd2,
        ST_PIX    = 2'd3
    } state_t;

    logic [1:0]     cs_sync_r, dc_sync_r, wr_sync_r, rd_sync_r;
    logic [7:0]     d_reg_r, d_dly_r;
    logic           wr_prev_r, rd_prev_r, wr_armed_r;
    logic           wr_evt_r, rd_evt_r;
    logic [7:0]     hold_d_r;
    logic           hold_dc_r;
    logic           cs_s, dc_s, wr_s, rd_s;

    state_t         state_r;
    logic [X_W-1:0] sc_r, ec_r, x_r, x_nxt_s, x_start_s, x_end_s;
    logic [Y_W-1:0] sp_r, ep_r, y_r, y_nxt_s, y_start_s, y_end_s;
    logic [1:0]     par_cnt_r, pix_cnt_r;
    logic [23:0]    par_buf_r;
    logic [15:0]    pix_buf_r;
    logic [23:0]    pix_word_s;
    logic           rd_pwr_r;
    logic           pix_valid_r, disp_on_r, d_oe_r;
    logic [X_W-1:0] pix_x_r;
    logic [Y_W-1:0] pix_y_r;
    logic [23:0]    pix_data_r;
    logic [7:0]     d_out_r;

    assign cs_s = cs_sync_r[1];
    assign dc_s = dc_sync_r[1];
    assign wr_s = wr_sync_r[1];
    assign rd_s = rd_sync_r[1];

    // Synchronizers, write-byte capture and strobe edge events.
    // d is delayed twice so it lines up with the synchronized strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_r  <= 2'b11;
            dc_sync_r  <= 2'b11;
            wr_sync_r  <= 2'b11;
            rd_sync_r  <= 2'b11;
            d_reg_r    <= 8'h00;
            d_dly_r    <= 8'h00;
            wr_prev_r  <= 1'b1;
            rd_prev_r  <= 1'b1;
            wr_armed_r <= 1'b0;
            wr_evt_r   <= 1'b0;
            rd_evt_r   <= 1'b0;
            hold_d_r   <= 8'h00;
            hold_dc_r  <= 1'b1;
        end else begin
            cs_sync_r <= {cs_sync_r[0], bus.cs_n};
            dc_sync_r <= {dc_sync_r[0], bus.dc_n};
            wr_sync_r <= {wr_sync_r[0], bus.wr_n};
            rd_sync_r <= {rd_sync_r[0], bus.rd_n};
            d_reg_r   <= bus.d_in;
            d_dly_r   <= d_reg_r;
            wr_prev_r <= wr_s;
            rd_prev_r <= rd_s;
            if (!wr_s && !cs_s) begin
                hold_d_r   <= d_dly_r;
                hold_dc_r  <= dc_s;
                wr_armed_r <= 1'b1;
            end else if (wr_s && !wr_prev_r) begin
                wr_armed_r <= 1'b0;
            end else begin
                wr_armed_r <= wr_armed_r;
            end
            wr_evt_r <= wr_s && !wr_prev_r && wr_armed_r;
            // A read strobe overlapping a write is ignored.
            rd_evt_r <= !rd_s && rd_prev_r && !cs_s && wr_s;
        end
    end

    // Window parameters, next-pixel address and pixel word assembly.
    always_comb begin
        x_start_s = X_W'(par_buf_r[23:8]);
        x_end_s   = X_W'({par_buf_r[7:0], hold_d_r});
        y_start_s = Y_W'(par_buf_r[23:8]);
        y_end_s   = Y_W'({par_buf_r[7:0], hold_d_r});
        if (x_r == ec_r) begin
            x_nxt_s = sc_r;
            if (y_r == ep_r) begin
                y_nxt_s = sp_r;
            end else begin
                y_nxt_s = y_r + Y_W'(1'b1);
            end
        end else begin
            x_nxt_s = x_r + X_W'(1'b1);
            y_nxt_s = y_r;
        end
`ifdef SSD1963_RX_RGB565_EN
        pix_word_s = rgb565_to_888({pix_buf_r[7:0], hold_d_r});
`else
        pix_word_s = {pix_buf_r, hold_d_r};
`endif
    end

    // Command/parameter decoder FSM with registered pixel and read outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IGNORE;
            sc_r        <= {X_W{1'b0}};
            ec_r        <= {X_W{1'b1}};
            sp_r        <= {Y_W{1'b0}};
            ep_r        <= {Y_W{1'b1}};
            x_r         <= {X_W{1'b0}};
            y_r         <= {Y_W{1'b0}};
            par_cnt_r   <= 2'd0;
            pix_cnt_r   <= 2'd0;
            par_buf_r   <= 24'h000000;
            pix_buf_r   <= 16'h0000;
            rd_pwr_r    <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_x_r     <= {X_W{1'b0}};
            pix_y_r     <= {Y_W{1'b0}};
            pix_data_r  <= 24'h000000;
            disp_on_r   <= 1'b0;
            d_oe_r      <= 1'b0;
            d_out_r     <= 8'h00;
        end else begin
            pix_valid_r <= 1'b0;
            if (wr_evt_r && !hold_dc_r) begin
                par_cnt_r <= 2'd0;
                pix_cnt_r <= 2'd0;
                rd_pwr_r  <= (hold_d_r == CMD_PWR);
                case (hold_d_r)
                    CMD_COL:     state_r <= ST_COL;
                    CMD_PAGE:    state_r <= ST_PAGE;
                    CMD_RAMWR: begin
                        state_r <= ST_PIX;
                        x_r     <= sc_r;
                        y_r     <= sp_r;
                    end
                    CMD_RAMCONT: state_r <= ST_PIX;
                    CMD_OFF: begin
                        disp_on_r <= 1'b0;
                        state_r   <= ST_IGNORE;
                    end
                    CMD_ON: begin
                        disp_on_r <= 1'b1;
                        state_r   <= ST_IGNORE;
                    end
                    default:     state_r <= ST_IGNORE;
                endcase
            end else if (wr_evt_r) begin
                case (state_r)
                    ST_COL, ST_PAGE: begin
                        if (par_cnt_r == 2'd3) begin
                            if (state_r == ST_COL) begin
                                sc_r <= x_start_s;
                                ec_r <= x_end_s;
                            end else begin
                                sp_r <= y_start_s;
                                ep_r <= y_end_s;
                            end
                            par_cnt_r <= 2'd0;
                            state_r   <= ST_IGNORE;
                        end else begin
                            par_buf_r <= {par_buf_r[15:0], hold_d_r};
                            par_cnt_r <= par_cnt_r + 2'd1;
                        end
                    end
                    ST_PIX: begin
                        if (pix_cnt_r == PIX_LAST) begin
                            pix_valid_r <= 1'b1;
                            pix_x_r     <= x_r;
                            pix_y_r     <= y_r;
                            pix_data_r  <= pix_word_s;
                            x_r         <= x_nxt_s;
                            y_r         <= y_nxt_s;
                            pix_cnt_r   <= 2'd0;
                        end else begin
                            pix_buf_r <= {pix_buf_r[7:0], hold_d_r};
                            pix_cnt_r <= pix_cnt_r + 2'd1;
                        end
                    end
                    default: state_r <= ST_IGNORE;
                endcase
            end else begin
                state_r <= state_r;
            end

            if (rd_evt_r) begin
                d_oe_r  <= 1'b1;
                d_out_r <= rd_pwr_r ? {5'b00000, disp_on_r, 2'b00} : 8'h00;
            end else if (rd_s || cs_s) begin
                d_oe_r <= 1'b0;
            end else begin
                d_oe_r <= d_oe_r;
            end
        end
    end

    assign pix_valid  = pix_valid_r;
    assign pix_x      = pix_x_r;
    assign pix_y      = pix_y_r;
    assign pix_data   = pix_data_r;
    assign disp_on    = disp_on_r;
    assign bus.d_out  = d_out_r;
    assign bus.d_oe   = d_oe_r;

endmodule

// File: tb/tb_ssd1963_rx.sv
// Randomized bench for ssd1963_rx: a host-level model of the command stream predicts
// every pixel (coordinates, data, latency) and every power-mode read.
module tb_ssd1963_rx;
    localparam int X_W = 11;
    localparam int Y_W = 11;
    localparam int XM  = 1 << X_W;
    localparam int YM  = 1 << Y_W;
`ifdef SSD1963_RX_RGB565_EN
    localparam int BPP = 2;
`else
    localparam int BPP = 3;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           pix_valid;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [23:0]    pix_data;
    logic           disp_on;

    ssd1963_rx_if bus();

    ssd1963_rx #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .disp_on(disp_on)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Host-level model: 0 ignore, 1 column, 2 page, 3 pixel
    int         m_state, m_sc, m_ec, m_sp, m_ep, m_x, m_y;
    logic [7:0] m_buf[$];
    bit         m_disp, m_pwr;

    function automatic void model_reset();
        m_state = 0; m_sc = 0; m_sp = 0; m_ec = XM - 1; m_ep = YM - 1;
        m_x = 0; m_y = 0; m_buf.delete(); m_disp = 0; m_pwr = 0;
    endfunction

    function automatic void model_write(input bit dc, input logic [7:0] d, output bit hit,
                                        output int ex, output int ey, output logic [23:0] edat);
        int s, e, v, r5, g6, b5;
        hit = 0; ex = 0; ey = 0; edat = 24'h0;
        if (!dc) begin
            m_buf.delete();
            m_pwr = (d == 8'h0A);
            case (d)
                8'h2A: m_state = 1;
                8'h2B: m_state = 2;
                8'h2C: begin m_state = 3; m_x = m_sc; m_y = m_sp; end
                8'h3C: m_state = 3;
                8'h28: begin m_disp = 0; m_state = 0; end
                8'h29: begin m_disp = 1; m_state = 0; end
                default: m_state = 0;
            endcase
        end else if (m_state == 1 || m_state == 2) begin
            m_buf.push_back(d);
            if (m_buf.size() == 4) begin
                s = int'(m_buf[0]) * 256 + int'(m_buf[1]);
                e = int'(m_buf[2]) * 256 + int'(m_buf[3]);
                if (m_state == 1) begin m_sc = s % XM; m_ec = e % XM; end
                else begin m_sp = s % YM; m_ep = e % YM; end
                m_state = 0;
                m_buf.delete();
            end
        end else if (m_state == 3) begin
            m_buf.push_back(d);
            if (m_buf.size() == BPP) begin
                hit = 1; ex = m_x; ey = m_y;
`ifdef SSD1963_RX_RGB565_EN
                v  = int'(m_buf[0]) * 256 + int'(m_buf[1]);
                r5 = v / 2048; g6 = (v / 32) % 64; b5 = v % 32;
                edat = 24'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256 + (b5 * 8 + b5 / 4));
`else
                v = 0; r5 = 0; g6 = 0; b5 = 0;
                edat = {m_buf[0], m_buf[1], m_buf[2]};
`endif
                m_buf.delete();
                if (m_x == m_ec) begin
                    m_x = m_sc;
                    m_y = (m_y == m_ep) ? m_sp : (m_y + 1) % YM;
                end else begin
                    m_x = (m_x + 1) % XM;
                end
            end
        end
    endfunction

    task automatic wr_byte(input bit dc, input logic [7:0] d);
        bit hit; int ex, ey, seen; logic [23:0] edat;
        logic [X_W-1:0] gx; logic [Y_W-1:0] gy; logic [23:0] gd;
        model_write(dc, d, hit, ex, ey, edat);
        seen = 0; gx = '0; gy = '0; gd = '0;
        @(negedge clk);
        bus.cs_n = 1'b0; bus.dc_n = dc; bus.d_in = d; bus.wr_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.wr_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (pix_valid && seen == 0) begin
                seen = k; gx = pix_x; gy = pix_y; gd = pix_data;
            end
        end
        if (hit) begin
            check("pix_latency", seen, 4);
            check("pix_x", gx, ex);
            check("pix_y", gy, ey);
            check("pix_data", gd, edat);
        end else begin
            check("no_pix", seen, 0);
        end
        bus.cs_n = 1'b1;
    endtask

    task automatic rd_check();
        logic [7:0] exp;
        exp = m_pwr ? (m_disp ? 8'h04 : 8'h00) : 8'h00;
        @(negedge clk);
        bus.cs_n = 1'b0; bus.rd_n = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) check("rd_oe_early", bus.d_oe, 1'b0);
            if (k == 4) check("rd_oe", bus.d_oe, 1'b1);
            if (k == 6) check("rd_data", bus.d_out, exp);
        end
        bus.rd_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rd_oe_release", bus.d_oe, 1'b0);
        bus.cs_n = 1'b1;
    endtask

    task automatic wr_rd_overlap(input logic [7:0] cmd);
        bit hit; int ex, ey, seen; logic [23:0] edat;
        model_write(1'b0, cmd, hit, ex, ey, edat);
        seen = 0;
        @(negedge clk);
        bus.cs_n = 1'b0; bus.dc_n = 1'b0; bus.d_in = cmd; bus.wr_n = 1'b0;
        @(negedge clk);
        bus.rd_n = 1'b0;
        repeat (5) @(negedge clk);
        bus.wr_n = 1'b1; bus.rd_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.d_oe) seen = k;
        end
        check("overlap_no_oe", seen, 0);
        bus.cs_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("pix_in_reset", pix_valid, 1'b0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic window(input logic [7:0] cmd, input int s, input int e);
        wr_byte(1'b0, cmd);
        wr_byte(1'b1, 8'(s >> 8)); wr_byte(1'b1, 8'(s));
        wr_byte(1'b1, 8'(e >> 8)); wr_byte(1'b1, 8'(e));
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n * BPP; i++) wr_byte(1'b1, 8'($urandom));
    endtask

    initial begin
        int r;
        bus.cs_n = 1'b1; bus.dc_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.d_in = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_d_oe", bus.d_oe, 1'b0);
        check("rst_d_out", bus.d_out, 8'h00);
        check("rst_disp_on", disp_on, 1'b0);

        wr_byte(1'b0, 8'h0A); rd_check();

        window(8'h2A, 2, 4);
        window(8'h2B, 1, 2);
        wr_byte(1'b0, 8'h2C);
        pixels(3); pixels(3); pixels(1);

        wr_byte(1'b0, 8'h2C);
        wr_byte(1'b1, 8'h11); wr_byte(1'b1, 8'h22);
        wr_byte(1'b0, 8'h3C);
        pixels(1);

        wr_byte(1'b0, 8'h29); check("disp_on_set", disp_on, 1'b1);
        wr_byte(1'b0, 8'h0A); rd_check();
        wr_byte(1'b0, 8'h28); check("disp_on_clr", disp_on, 1'b0);
        wr_byte(1'b0, 8'h0A); rd_check();

        wr_byte(1'b0, 8'h2C);
        wr_byte(1'b1, 8'hA5); wr_byte(1'b1, 8'h5A);
        do_reset();
        wr_byte(1'b1, 8'h3C);
        wr_byte(1'b0, 8'h2C);
        pixels(1);

        wr_rd_overlap(8'h29);
        wr_byte(1'b0, 8'h0A); rd_check();

        window(8'h2A, 2045, 1);
        window(8'h2B, 7, 6);
        wr_byte(1'b0, 8'h2C);
        pixels(6);

        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       window(8'h2A, $urandom_range(0, 65535), $urandom_range(0, 65535));
            else if (r < 6)  window(8'h2B, $urandom_range(0, 65535), $urandom_range(0, 65535));
            else if (r < 10) window(($urandom_range(0, 1) != 0) ? 8'h2A : 8'h2B,
                                    $urandom_range(0, 6), $urandom_range(0, 6));
            else if (r < 16) wr_byte(1'b0, 8'h2C);
            else if (r < 20) wr_byte(1'b0, 8'h3C);
            else if (r < 22) wr_byte(1'b0, 8'h28);
            else if (r < 24) wr_byte(1'b0, 8'h29);
            else if (r < 28) begin wr_byte(1'b0, 8'h0A); rd_check(); end
            else if (r < 30) rd_check();
            else if (r < 32) wr_byte(1'b0, 8'($urandom));
            else             wr_byte(1'b1, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
